// File: rtl/sme_pattern_parser_pkg.sv
// ============================================================================
//  Module   : sme_pattern_parser_pkg
//  Purpose  : Shared metacharacter codes and FSM encoding for the pattern parser
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sme_pattern_parser_pkg;

    localparam logic [7:0] CH_HEAD = 8'h5E;
    localparam logic [7:0] CH_TAIL = 8'h24;
    localparam logic [7:0] CH_ANY  = 8'h2E;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_NUL  = 8'h00;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sme_char_class.sv
// ============================================================================
//  Module   : sme_char_class
//  Purpose  : Combinational classifier for one pattern character
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sme_char_class
    import sme_pattern_parser_pkg::*;
(
    input  logic [7:0] i_chardata,
    input  logic       i_is_first,
    output logic       o_is_head,
    output logic       o_is_star,
    output logic       o_is_any,
    output logic       o_is_tok
);

    // '^' is only an anchor in the first position; anywhere else it is a literal.
    assign o_is_head = i_is_first && (i_chardata == CH_HEAD);
    assign o_is_star = (i_chardata == CH_STAR);
    assign o_is_any  = (i_chardata == CH_ANY);
    assign o_is_tok  = !o_is_head && !o_is_star;

endmodule

`default_nettype wire

// File: rtl/sme_pattern_parser.sv
// ============================================================================
//  Module   : sme_pattern_parser
//  Purpose  : Compiles the serial pattern stream into a held token record
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sme_pattern_parser
    import sme_pattern_parser_pkg::*;
#(
    parameter int MAX_TOK = 8,
    parameter int TOK_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           chardata,
    input  logic                 ispattern,
    input  logic                 pat_ack,
    output logic                 pat_valid,
    output logic [8*MAX_TOK-1:0] tok_char,
    output logic [MAX_TOK-1:0]   tok_any,
    output logic [TOK_W-1:0]     tok_len,
    output logic                 anchor_head,
    output logic                 anchor_tail,
    output logic                 star_en,
    output logic [TOK_W-1:0]     star_pos,
    output logic                 pat_err
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    logic [8*MAX_TOK-1:0] r_tok_char,  w_tok_char;
    logic [MAX_TOK-1:0]   r_tok_any,   w_tok_any;
    logic [TOK_W-1:0]     r_cnt,       w_cnt;
    logic                 r_head,      w_head;
    logic                 r_tail,      w_tail;
    logic                 r_star_en,   w_star_en;
    logic [TOK_W-1:0]     r_star_pos,  w_star_pos;
    logic                 r_err,       w_err;
    logic                 r_pend,      w_pend;
    logic [TOK_W-1:0]     r_pend_idx,  w_pend_idx;

    logic w_start;
    logic w_finalize;
    logic w_is_head;
    logic w_is_star;
    logic w_is_any;
    logic w_is_tok;

    // Any pattern char outside CAPTURE opens a fresh record, including from HOLD.
    assign w_start    = ispattern && (r_state != ST_CAPTURE);
    assign w_finalize = (r_state == ST_CAPTURE) && !ispattern;

    sme_char_class u_char_class (
        .i_chardata (chardata),
        .i_is_first (w_start),
        .o_is_head  (w_is_head),
        .o_is_star  (w_is_star),
        .o_is_any   (w_is_any),
        .o_is_tok   (w_is_tok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (ispattern)  w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (!ispattern) w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (ispattern)    w_state_nxt = ST_CAPTURE;
                else if (pat_ack) w_state_nxt = ST_IDLE;
            end
            default:            w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pat_valid = (r_state == ST_HOLD);
    end

    // Working record update: clear on start, then fold in the current char.
    always_comb begin
        w_tok_char = r_tok_char;
        w_tok_any  = r_tok_any;
        w_cnt      = r_cnt;
        w_head     = r_head;
        w_tail     = r_tail;
        w_star_en  = r_star_en;
        w_star_pos = r_star_pos;
        w_err      = r_err;
        w_pend     = r_pend;
        w_pend_idx = r_pend_idx;

        if (w_start) begin
            w_tok_char = '0;
            w_tok_any  = '0;
            w_cnt      = '0;
            w_head     = 1'b0;
            w_tail     = 1'b0;
            w_star_en  = 1'b0;
            w_star_pos = '0;
            w_err      = 1'b0;
            w_pend     = 1'b0;
            w_pend_idx = '0;
        end

        if (ispattern) begin
            w_pend = 1'b0;
            if (w_is_head) begin
                w_head = 1'b1;
            end else if (w_is_star) begin
                if (w_star_en) begin
                    w_err = 1'b1;
                end else begin
                    w_star_en  = 1'b1;
                    w_star_pos = w_cnt;
                end
            end else if (w_is_tok) begin
                if (w_cnt == TOK_W'(MAX_TOK)) begin
                    w_err = 1'b1;
                end else begin
                    for (int i = 0; i < MAX_TOK; i++) begin
                        if (w_cnt == TOK_W'(i)) begin
                            w_tok_char[8*i +: 8] = chardata;
                            w_tok_any[i]         = w_is_any;
                        end
                    end
                    w_pend     = (chardata == CH_TAIL);
                    w_pend_idx = w_cnt;
                    w_cnt      = w_cnt + TOK_W'(1);
                end
            end
        end

        // A trailing '$' becomes the tail anchor instead of a token.
        if (w_finalize) begin
            if (r_pend) begin
                w_cnt  = r_cnt - TOK_W'(1);
                w_tail = 1'b1;
                w_pend = 1'b0;
                for (int i = 0; i < MAX_TOK; i++) begin
                    if (r_pend_idx == TOK_W'(i)) begin
                        w_tok_char[8*i +: 8] = CH_NUL;
                        w_tok_any[i]         = 1'b0;
                    end
                end
            end
            if (w_star_pos > w_cnt) begin
                w_star_pos = w_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tok_char <= '0;
            r_tok_any  <= '0;
            r_cnt      <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_star_en  <= 1'b0;
            r_star_pos <= '0;
            r_err      <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            r_tok_char <= w_tok_char;
            r_tok_any  <= w_tok_any;
            r_cnt      <= w_cnt;
            r_head     <= w_head;
            r_tail     <= w_tail;
            r_star_en  <= w_star_en;
            r_star_pos <= w_star_pos;
            r_err      <= w_err;
            r_pend     <= w_pend;
            r_pend_idx <= w_pend_idx;
        end
    end

    assign tok_char    = r_tok_char;
    assign tok_any     = r_tok_any;
    assign tok_len     = r_cnt;
    assign anchor_head = r_head;
    assign anchor_tail = r_tail;
    assign star_en     = r_star_en;
    assign star_pos    = r_star_pos;
    assign pat_err     = r_err;

endmodule

`default_nettype wire

// File: doc/sme_pattern_parser.md
Name: sme_pattern_parser

Overview:
- Upstream stage of the string-matching engine. Captures the serial pattern stream (chardata qualified by ispattern) and converts it into a compiled token record for the comparator.
- The record holds literal and any-char tokens, the head/tail anchor flags, the star position and an error flag.
- The record is held stable under a valid/ack handshake until the comparator consumes it.
- This removes metacharacter decoding from the comparator datapath.

Parameters:
- MAX_TOK, 8, maximum stored tokens (pattern characters after metacharacter removal)
- TOK_W, 4, width of token counts and positions; must satisfy 2^TOK_W > MAX_TOK

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- chardata  input  8  pattern character, ASCII
- ispattern  input  1  chardata is a pattern character this cycle; high for consecutive cycles per pattern
- pat_ack  input  1  comparator consumed the held record
- pat_valid  output  1  record fields are valid and stable
- tok_char  output  8*MAX_TOK  token i in bits [8i+7:8i]; token 0 is the first stored; unused slots 8'h00
- tok_any  output  MAX_TOK  bit i set: token i is '.' (matches any char)
- tok_len  output  TOK_W  number of stored tokens, 0..MAX_TOK
- anchor_head  output  1  pattern began with '^'
- anchor_tail  output  1  pattern ended with '$'
- star_en  output  1  pattern contained one '*'
- star_pos  output  TOK_W  tokens preceding '*' (0..tok_len)
- pat_err  output  1  token overflow or second '*'

Behaviour:
- Reset: all outputs 0, tok_char all 8'h00, FSM in IDLE, internal counters and pending flags cleared. Reset mid-capture or mid-hold discards everything.
- FSM states: IDLE, CAPTURE, HOLD.
- IDLE: ispattern=1 -> CAPTURE. The current char is processed as pattern position 0, and all working fields are cleared in the same cycle.
- CAPTURE with ispattern=1: process the char.
- CAPTURE with ispattern=0: finalize and go to HOLD. pat_valid=1 from the next cycle.
- Latency: last pattern char in cycle N, ispattern low in N+1, pat_valid high in N+2.
- HOLD: all outputs frozen while pat_valid=1.
  - pat_ack=1 -> IDLE; pat_valid=0 the next cycle.
  - ispattern=1 (with or without ack) -> new capture starts with that char as position 0. pat_valid=0 the next cycle, and the held record is discarded.
  - ispattern has priority over pat_ack.
- Char classification, applied in order:
  - '^' (8'h5E) at position 0: sets anchor_head, no token. Elsewhere it is a literal.
  - '*' (8'h2A): first occurrence sets star_en and star_pos = current token count, no token. A second occurrence sets pat_err and is otherwise ignored.
  - '.' (8'h2E): stores a token, tok_char=8'h2E, tok_any bit=1.
  - '$' (8'h24): stored as a literal token and the token index is recorded as pending-tail. If a later char arrives, the pending-tail mark is cleared and the token stays literal.
  - Any other value: literal token, tok_any bit=0.
- Finalize: if pending-tail is set, tok_len decrements, that slot is cleared to 8'h00 (tok_any bit cleared), and anchor_tail=1.
  - If star_pos exceeds the resulting tok_len, star_pos is clamped to tok_len.
- Overflow: a token-producing char when the count = MAX_TOK sets pat_err. The char is dropped, the count saturates, and pending-tail is not recorded for dropped chars.
- pat_err is sticky until the next capture start. The record is still delivered, with pat_valid asserted.
- Empty result (e.g. "^", "$", "^*$"): tok_len=0, pat_valid still asserted.
- All arithmetic is unsigned TOK_W bits; counters never wrap.

Decomposition:
- Shared package: metachar constants (CH_HEAD 8'h5E, CH_TAIL 8'h24, CH_ANY 8'h2E, CH_STAR 8'h2A, CH_NUL 8'h00) and the FSM state encoding (IDLE/CAPTURE/HOLD, 2 bits).
- One sub-module: sme_char_class. Combinational classifier taking chardata and an is-first flag; outputs is_head, is_star, is_any, is_tok. The token store and FSM stay in the parent.

Test Plan:
- "^ab.c" then ispattern low, then ack:
  - tok_len=4, tok_char="a","b",".","c", tok_any=4'b0100, anchor_head=1, anchor_tail=0, star_en=0, pat_err=0.
  - pat_valid rises 2 cycles after the 'c' cycle and falls 1 cycle after ack.
- "ab*c$":
  - tok_len=3 (a,b,c), star_en=1, star_pos=2, anchor_tail=1, slot 3 = 8'h00.
  - "a$b": tok_len=3, '$' literal in slot 1, anchor_tail=0.
- "abcdefghij" (10 literals):
  - tok_len=8, tok_char=a..h, pat_err=1.
  - Next pattern "x" clears pat_err: tok_len=1.
- "a*b*":
  - star_pos=1, pat_err=1, tok_len=2.
  - "^*$": tok_len=0, anchor_head=1, anchor_tail=1, star_en=1, star_pos=0.
- Hold without ack for 5 cycles:
  - Outputs stable throughout.
  - Then "q" arrives with no ack: pat_valid=0 the next cycle, and the new record later shows tok_len=1, tok_char[7:0]="q".
- Reset asserted during CAPTURE after "ab": all outputs 0 immediately. The following "z" pattern yields tok_len=1 with no residue from "ab".
